// File: rtl/inst_fetch_recv_pkg.sv
// Shared types and constants for the instruction-fetch response path.
// Optional build macro: FETCH_BYPASS_EN (empty-FIFO bypass in inst_fetch_recv).
package inst_fetch_recv_pkg;

    localparam logic [31:0] RESET_ADDR  = 32'hbfc00000;
    localparam logic [31:0] EXCEPT_ADDR = 32'hbfc00380;
    localparam logic [31:0] NOP_INST    = 32'h00000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_recv_if.sv
// Fetch request/response and decode-side handshake bundle.
// slave = the fetch receiver, master = PC generator plus decode stage.
interface inst_fetch_recv_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_adel;
    logic [31:0] rsp_rdata;
    logic        flush;
    logic        fetch_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    modport slave (
        input  req_valid, req_addr, req_adel, rsp_rdata, flush, out_ready,
        output fetch_ready, out_valid, out_pc, out_inst, out_adel
    );

    modport master (
        output req_valid, req_addr, req_adel, rsp_rdata, flush, out_ready,
        input  fetch_ready, out_valid, out_pc, out_inst, out_adel
    );
endinterface

// File: rtl/inst_fetch_recv_fifo.sv
// Small circular buffer of fetch entries with push/pop/clear and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import inst_fetch_recv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop & (count_q != '0);
        // a push at full is legal only when the head leaves in the same cycle
        do_push = push & ((count_q != CW'(DEPTH)) | do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = push_data;
                wptr_d        = wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/inst_fetch_recv.sv
// Pairs SRAM read data with the PC issued a cycle earlier and queues {pc,inst,adel} for decode.
// FETCH_BYPASS_EN: an empty FIFO forwards the arriving response combinationally.
//   state  | meaning
//   IDLE   | no fetch outstanding
//   WAIT   | SRAM data for the pending PC arrives this cycle
//   SQUASH | data arriving this cycle belongs to a flushed path, drop it
module inst_fetch_recv #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = inst_fetch_recv_pkg::RESET_ADDR,
    parameter logic [31:0] NOP_INST = inst_fetch_recv_pkg::NOP_INST
) (
    input logic                clk,
    input logic                rst,
    inst_fetch_recv_if.slave   bus
);
    import inst_fetch_recv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic          pend_adel_q, pend_adel_d;

    logic          accept;
    logic          rsp_live;
    logic          bypass;
    logic          push;
    logic          fifo_pop;
    logic          out_pop;
    logic          out_valid;
    logic          fetch_ready;
    int            occupancy;
    fetch_entry_t  new_entry;
    fetch_entry_t  head;
    logic [CW-1:0] count;
    logic          empty;

    always_comb begin
        rsp_live       = (state_q == WAIT) & ~bus.flush;
        new_entry.pc   = pend_addr_q;
        new_entry.inst = pend_adel_q ? NOP_INST : bus.rsp_rdata;
        new_entry.adel = pend_adel_q;
`ifdef FETCH_BYPASS_EN
        bypass         = empty & rsp_live;
`else
        bypass         = 1'b0;
`endif
        out_valid      = ~empty | bypass;
        out_pop        = out_valid & bus.out_ready;
        // a bypassed entry consumed by decode never enters the FIFO
        push           = rsp_live & ~(bypass & bus.out_ready);
        fifo_pop       = ~empty & bus.out_ready & ~bus.flush;
        occupancy      = int'(count) - int'(out_pop) + int'(state_q == WAIT);
        fetch_ready    = (occupancy < DEPTH);
        accept         = bus.req_valid & fetch_ready;
    end

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_adel_d = pend_adel_q;
        if (accept) begin
            pend_addr_d = bus.req_addr;
            pend_adel_d = bus.req_adel;
        end
        case (state_q)
            IDLE:    state_d = accept ? WAIT : IDLE;
            WAIT: begin
                if (bus.flush)  state_d = SQUASH;
                else if (accept) state_d = WAIT;
                else             state_d = IDLE;
            end
            SQUASH:  state_d = accept ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_addr_q <= RESET_PC;
            pend_adel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_adel_q <= pend_adel_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.flush),
        .push      (push),
        .push_data (new_entry),
        .pop       (fifo_pop),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    always_comb begin
        bus.fetch_ready = fetch_ready;
        bus.out_valid   = out_valid;
        bus.out_pc      = RESET_PC;
        bus.out_inst    = NOP_INST;
        bus.out_adel    = 1'b0;
        if (bypass) begin
            bus.out_pc   = new_entry.pc;
            bus.out_inst = new_entry.inst;
            bus.out_adel = new_entry.adel;
        end else if (~empty) begin
            bus.out_pc   = head.pc;
            bus.out_inst = head.inst;
            bus.out_adel = head.adel;
        end
    end

endmodule

// File: tb/tb_inst_fetch_recv.sv
// Directed bench for inst_fetch_recv (DEPTH=2); honours FETCH_BYPASS_EN for latency checks.
module tb_inst_fetch_recv;
    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    inst_fetch_recv_if bus ();

    inst_fetch_recv #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_adel  = 1'b0;
        bus.rsp_rdata = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        next_cycle();
        next_cycle();
        mid();
        chk("rst_valid", 32'(bus.out_valid),   32'd0);
        chk("rst_pc",    bus.out_pc,           32'hbfc00000);
        chk("rst_inst",  bus.out_inst,         32'h00000000);
        chk("rst_adel",  32'(bus.out_adel),    32'd0);
        chk("rst_ready", 32'(bus.fetch_ready), 32'd1);
        next_cycle();
        rst = 1'b0;

        // basic fetch with decode always ready
        bus.req_valid = 1'b1; bus.req_addr = 32'hbfc00000; bus.out_ready = 1'b1;
        mid();
        chk("t1_ready", 32'(bus.fetch_ready), 32'd1);
        next_cycle();
        bus.req_valid = 1'b0; bus.rsp_rdata = 32'h24080001;
        mid();
`ifdef FETCH_BYPASS_EN
        chk("t1_n1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_n1_inst",  bus.out_inst,       32'h24080001);
`else
        chk("t1_n1_valid", 32'(bus.out_valid), 32'd0);
`endif
        next_cycle();
        bus.rsp_rdata = 32'h0;
        mid();
`ifdef FETCH_BYPASS_EN
        chk("t1_n2_valid", 32'(bus.out_valid), 32'd0);
`else
        chk("t1_n2_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_n2_pc",    bus.out_pc,         32'hbfc00000);
        chk("t1_n2_inst",  bus.out_inst,       32'h24080001);
        chk("t1_n2_adel",  32'(bus.out_adel),  32'd0);
`endif
        next_cycle();
        mid();
        chk("t1_drain", 32'(bus.out_valid), 32'd0);
        next_cycle();

        // back-pressure: fill both entries, then drain in order
        bus.out_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 32'hbfc00004;
        mid();
        chk("t2_c0_ready", 32'(bus.fetch_ready), 32'd1);
        next_cycle();
        bus.req_addr = 32'hbfc00008; bus.rsp_rdata = 32'haaaa0000;
        mid();
        chk("t2_c1_ready", 32'(bus.fetch_ready), 32'd1);
        next_cycle();
        bus.req_addr = 32'hbfc0000c; bus.rsp_rdata = 32'haaaa0001;
        mid();
        chk("t2_c2_ready", 32'(bus.fetch_ready), 32'd0);
        next_cycle();
        bus.rsp_rdata = 32'h0;
        mid();
        chk("t2_c3_ready", 32'(bus.fetch_ready), 32'd0);
        chk("t2_c3_valid", 32'(bus.out_valid),   32'd1);
        chk("t2_c3_pc",    bus.out_pc,           32'hbfc00004);
        next_cycle();
        bus.out_ready = 1'b1;
        mid();
        chk("t2_c4_ready", 32'(bus.fetch_ready), 32'd1);
        chk("t2_c4_pc",    bus.out_pc,           32'hbfc00004);
        chk("t2_c4_inst",  bus.out_inst,         32'haaaa0000);
        next_cycle();
        bus.out_ready = 1'b0; bus.req_valid = 1'b0; bus.rsp_rdata = 32'haaaa0002;
        mid();
        chk("t2_c5_pc",    bus.out_pc,           32'hbfc00008);
        chk("t2_c5_inst",  bus.out_inst,         32'haaaa0001);
        chk("t2_c5_ready", 32'(bus.fetch_ready), 32'd0);
        next_cycle();
        bus.out_ready = 1'b1; bus.rsp_rdata = 32'h0;
        mid();
        chk("t2_c6_pc", bus.out_pc, 32'hbfc00008);
        next_cycle();
        mid();
        chk("t2_c7_pc",   bus.out_pc,   32'hbfc0000c);
        chk("t2_c7_inst", bus.out_inst, 32'haaaa0002);
        next_cycle();
        bus.out_ready = 1'b0;
        mid();
        chk("t2_c8_valid", 32'(bus.out_valid), 32'd0);
        next_cycle();

        // misaligned fetch substitutes the NOP
        bus.req_valid = 1'b1; bus.req_addr = 32'hbfc00002; bus.req_adel = 1'b1;
        next_cycle();
        bus.req_valid = 1'b0; bus.req_adel = 1'b0; bus.rsp_rdata = 32'hdeadbeef;
        next_cycle();
        bus.rsp_rdata = 32'h0; bus.out_ready = 1'b1;
        mid();
        chk("t3_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_pc",    bus.out_pc,         32'hbfc00002);
        chk("t3_inst",  bus.out_inst,       32'h00000000);
        chk("t3_adel",  32'(bus.out_adel),  32'd1);
        next_cycle();
        bus.out_ready = 1'b0;
        mid();
        chk("t3_drain", 32'(bus.out_valid), 32'd0);
        next_cycle();

        // flush while WAIT with one buffered entry, then redirect fetch
        bus.req_valid = 1'b1; bus.req_addr = 32'hbfc00010;
        next_cycle();
        bus.req_addr = 32'hbfc00014; bus.rsp_rdata = 32'h11111111;
        mid();
        chk("t4_c1_ready", 32'(bus.fetch_ready), 32'd1);
        next_cycle();
        bus.req_valid = 1'b0; bus.flush = 1'b1; bus.rsp_rdata = 32'h22222222;
        mid();
        chk("t4_c2_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_c2_pc",    bus.out_pc,         32'hbfc00010);
        next_cycle();
        bus.flush = 1'b0; bus.rsp_rdata = 32'h33333333;
        bus.req_valid = 1'b1; bus.req_addr = 32'hbfc00380;
        mid();
        chk("t4_c3_valid", 32'(bus.out_valid),   32'd0);
        chk("t4_c3_pc",    bus.out_pc,           32'hbfc00000);
        chk("t4_c3_ready", 32'(bus.fetch_ready), 32'd1);
        next_cycle();
        bus.req_valid = 1'b0; bus.rsp_rdata = 32'h3c1a8000;
        next_cycle();
        bus.rsp_rdata = 32'h0; bus.out_ready = 1'b1;
        mid();
        chk("t4_c5_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_c5_pc",    bus.out_pc,         32'hbfc00380);
        chk("t4_c5_inst",  bus.out_inst,       32'h3c1a8000);
        chk("t4_c5_adel",  32'(bus.out_adel),  32'd0);
        next_cycle();
        bus.out_ready = 1'b0;
        mid();
        chk("t4_drain", 32'(bus.out_valid), 32'd0);
        next_cycle();

        // reset with a buffered entry and a fetch in flight
        bus.req_valid = 1'b1; bus.req_addr = 32'hbfc00020;
        next_cycle();
        bus.req_addr = 32'hbfc00024; bus.rsp_rdata = 32'h44444444;
        next_cycle();
        bus.req_valid = 1'b0; bus.rsp_rdata = 32'h55555555; rst = 1'b1;
        mid();
        chk("t5_pre_valid", 32'(bus.out_valid),   32'd1);
        chk("t5_pre_ready", 32'(bus.fetch_ready), 32'd0);
        next_cycle();
        rst = 1'b0; bus.rsp_rdata = 32'h66666666;
        mid();
        chk("t5_valid", 32'(bus.out_valid),   32'd0);
        chk("t5_pc",    bus.out_pc,           32'hbfc00000);
        chk("t5_inst",  bus.out_inst,         32'h00000000);
        chk("t5_adel",  32'(bus.out_adel),    32'd0);
        chk("t5_ready", 32'(bus.fetch_ready), 32'd1);
        next_cycle();
        mid();
        chk("t5_post_valid", 32'(bus.out_valid), 32'd0);
        next_cycle();

`ifdef FETCH_BYPASS_EN
        // bypass: empty FIFO, decode ready, data forwarded at N+1 and not kept
        bus.out_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'hbfc00040;
        next_cycle();
        bus.req_valid = 1'b0; bus.rsp_rdata = 32'h77777777;
        mid();
        chk("t6_valid", 32'(bus.out_valid),   32'd1);
        chk("t6_pc",    bus.out_pc,           32'hbfc00040);
        chk("t6_inst",  bus.out_inst,         32'h77777777);
        chk("t6_ready", 32'(bus.fetch_ready), 32'd1);
        next_cycle();
        bus.rsp_rdata = 32'h0;
        mid();
        chk("t6_nopush", 32'(bus.out_valid), 32'd0);
        next_cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
